// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device transmitter: inhibit, request-to-send,
//               device-clocked serialization of one byte and ACK check.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLK_chaos,
    input  logic       restart,
    input  logic [7:0] dato_tx,
    input  logic       enviar,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       ocupado,
    output logic       listo,
    output logic       error
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_INHIBIT  = 3'd1;
    localparam logic [2:0] c_REQ      = 3'd2;
    localparam logic [2:0] c_TX       = 3'd3;
    localparam logic [2:0] c_WAIT_REL = 3'd4;

    localparam logic [19:0] c_INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] c_TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    logic [2:0]  r_state;
    logic        r_clk_s1, r_clk_s2, r_clk_prev;
    logic        r_dat_s1, r_dat_s2;
    logic [19:0] r_cnt;
    logic [3:0]  r_n;
    logic [7:0]  r_shreg;
    logic        r_par;
    logic        r_clk_oe, r_data_oe, r_ocupado, r_listo, r_error;
    logic        w_fall;
    logic        w_timeout;

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    // Counter value cycle k means the error pulse lands exactly TIMEOUT_CYCLES after release.
    assign w_timeout = (r_cnt == c_TIMEOUT_LAST);

    always_ff @(posedge CLK_chaos) begin
        if (restart) begin
            r_state    <= c_IDLE;
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_cnt      <= '0;
            r_n        <= '0;
            r_shreg    <= '0;
            r_par      <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_ocupado  <= 1'b0;
            r_listo    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data_in;
            r_dat_s2   <= r_dat_s1;
            r_listo    <= 1'b0;
            r_error    <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (enviar) begin
                        r_shreg   <= dato_tx;
                        r_par     <= ~^dato_tx;
                        r_cnt     <= '0;
                        r_n       <= '0;
                        r_clk_oe  <= 1'b1;
                        r_data_oe <= 1'b0;
                        r_ocupado <= 1'b1;
                        r_state   <= c_INHIBIT;
                    end
                end
                c_INHIBIT: begin
                    if (r_cnt == c_INHIBIT_LAST) begin
                        r_cnt     <= '0;
                        r_data_oe <= 1'b1;
                        r_state   <= c_REQ;
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
                c_REQ: begin
                    r_clk_oe <= 1'b0;
                    r_cnt    <= '0;
                    r_state  <= c_TX;
                end
                c_TX: begin
                    if (w_timeout) begin
                        r_data_oe <= 1'b0;
                        r_ocupado <= 1'b0;
                        r_error   <= 1'b1;
                        r_state   <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                        if (w_fall) begin
                            r_n <= r_n + 4'd1;
                            // r_n still holds the previous edge count, i.e. the bit index.
                            if (r_n < 4'd8) begin
                                r_data_oe <= ~r_shreg[r_n[2:0]];
                            end else if (r_n == 4'd8) begin
                                r_data_oe <= ~r_par;
                            end else if (r_n == 4'd9) begin
                                r_data_oe <= 1'b0;
                            end else if (r_dat_s2 == 1'b0) begin
                                r_state <= c_WAIT_REL;
                            end else begin
                                r_data_oe <= 1'b0;
                                r_ocupado <= 1'b0;
                                r_error   <= 1'b1;
                                r_state   <= c_IDLE;
                            end
                        end
                    end
                end
                c_WAIT_REL: begin
                    if (w_timeout) begin
                        r_ocupado <= 1'b0;
                        r_error   <= 1'b1;
                        r_state   <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                        if (r_clk_s2 && r_dat_s2) begin
                            r_ocupado <= 1'b0;
                            r_listo   <= 1'b1;
                            r_state   <= c_IDLE;
                        end
                    end
                end
                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_ocupado <= 1'b0;
                    r_state   <= c_IDLE;
                end
            endcase
        end
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign ocupado     = r_ocupado;
    assign listo       = r_listo;
    assign error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Directed bench for ps2_host_tx with a simple PS/2 device model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_host_tx;

    logic       CLK_chaos = 1'b0;
    logic       restart   = 1'b1;
    logic [7:0] dato_tx   = 8'h00;
    logic       enviar    = 1'b0;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe, ocupado, listo, error;

    int checks = 0;
    int errors = 0;

    // Monitor state, written only by the monitor process.
    int   cyc = 0, n_listo = 0, n_err = 0, n_clkoe = 0, n_req = 0, n_viol = 0;
    int   t_rel = 0, t_err = 0;
    logic prev_clkoe = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(8), .TIMEOUT_CYCLES(2000)) dut (
        .CLK_chaos   (CLK_chaos),
        .restart     (restart),
        .dato_tx     (dato_tx),
        .enviar      (enviar),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .ocupado     (ocupado),
        .listo       (listo),
        .error       (error)
    );

    always #5 CLK_chaos = ~CLK_chaos;

    always @(negedge CLK_chaos) begin
        cyc = cyc + 1;
        if (listo)  n_listo = n_listo + 1;
        if (error)  begin n_err = n_err + 1; t_err = cyc; end
        if (ps2_clk_oe) n_clkoe = n_clkoe + 1;
        if (ps2_clk_oe && ps2_data_oe) n_req = n_req + 1;
        if (prev_clkoe && !ps2_clk_oe) t_rel = cyc;
        prev_clkoe = ps2_clk_oe;
        if (listo && error) n_viol = n_viol + 1;
        if ((listo || error) && ocupado) n_viol = n_viol + 1;
        if ((ps2_clk_oe || ps2_data_oe) && !ocupado) n_viol = n_viol + 1;
    end

    task automatic start_tx(input logic [7:0] b);
        @(negedge CLK_chaos);
        dato_tx = b;
        enviar  = 1'b1;
        @(negedge CLK_chaos);
        enviar  = 1'b0;
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK_chaos);
            if (ocupado === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    // Device model: waits for the host to release the clock, then clocks 11 bits
    // at a 40-cycle period, sampling data at each rising edge.
    task automatic device_frame(input logic ack, input int abort_at,
                                output logic [9:0] smp, output logic ok);
        ok  = 1'b0;
        smp = '0;
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK_chaos);
            if (ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1 && ocupado === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        repeat (10) @(negedge CLK_chaos);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) begin
                dev_data_low = ack;
                repeat (5) @(negedge CLK_chaos);
            end
            dev_clk_low = 1'b1;
            if (i == abort_at) begin
                repeat (5) @(negedge CLK_chaos);
                restart = 1'b1;
                @(negedge CLK_chaos);
                restart     = 1'b0;
                dev_clk_low = 1'b0;
                return;
            end
            repeat (20) @(negedge CLK_chaos);
            if (i <= 10) smp[i-1] = ps2_data_in;
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
            repeat (20) @(negedge CLK_chaos);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK_chaos);
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, ocupado, listo, error} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 00000",
                     {ps2_clk_oe, ps2_data_oe, ocupado, listo, error});
        end
        restart = 1'b0;
        repeat (3) @(negedge CLK_chaos);
    endtask

    task automatic test_send(input logic [7:0] b, input logic exp_par);
        logic [9:0] smp;
        logic ok, ok2;
        int l0, e0, c0, r0;
        l0 = n_listo; e0 = n_err; c0 = n_clkoe; r0 = n_req;
        start_tx(b);
        device_frame(1'b1, 0, smp, ok);
        wait_idle(ok2);
        repeat (10) @(negedge CLK_chaos);
        checks++;
        if (!(ok && ok2)) begin errors++; $display("FAIL send_handshake got %b%b exp 11", ok, ok2); end
        checks++;
        if (smp[7:0] !== b) begin errors++; $display("FAIL send_data got %h exp %h", smp[7:0], b); end
        checks++;
        if (smp[8] !== exp_par) begin errors++; $display("FAIL send_parity got %b exp %b", smp[8], exp_par); end
        checks++;
        if (smp[9] !== 1'b1) begin errors++; $display("FAIL send_stop got %b exp 1", smp[9]); end
        checks++;
        if (n_listo - l0 !== 1) begin errors++; $display("FAIL send_listo got %0d exp 1", n_listo - l0); end
        checks++;
        if (n_err - e0 !== 0) begin errors++; $display("FAIL send_error got %0d exp 0", n_err - e0); end
        checks++;
        if (n_clkoe - c0 !== 9) begin errors++; $display("FAIL send_clk_oe_cycles got %0d exp 9", n_clkoe - c0); end
        checks++;
        if (n_req - r0 !== 1) begin errors++; $display("FAIL send_req_cycles got %0d exp 1", n_req - r0); end
        checks++;
        if (ocupado !== 1'b0) begin errors++; $display("FAIL send_ocupado got %b exp 0", ocupado); end
    endtask

    task automatic test_no_ack();
        logic [9:0] smp;
        logic ok;
        int l0, e0;
        l0 = n_listo; e0 = n_err;
        start_tx(8'h3C);
        device_frame(1'b0, 0, smp, ok);
        repeat (20) @(negedge CLK_chaos);
        checks++;
        if (n_err - e0 !== 1) begin errors++; $display("FAIL noack_error got %0d exp 1", n_err - e0); end
        checks++;
        if (n_listo - l0 !== 0) begin errors++; $display("FAIL noack_listo got %0d exp 0", n_listo - l0); end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, ocupado} !== 3'b000) begin
            errors++;
            $display("FAIL noack_lines got %b exp 000", {ps2_clk_oe, ps2_data_oe, ocupado});
        end
    endtask

    task automatic test_timeout();
        logic seen;
        int l0, e0;
        l0 = n_listo; e0 = n_err; seen = 1'b0;
        start_tx(8'hA5);
        for (int k = 0; k < 2500; k++) begin
            @(negedge CLK_chaos);
            if (error === 1'b1) begin seen = 1'b1; break; end
        end
        repeat (5) @(negedge CLK_chaos);
        checks++;
        if (!seen) begin errors++; $display("FAIL timeout_seen got 0 exp 1"); end
        checks++;
        if (t_err - t_rel !== 2000) begin errors++; $display("FAIL timeout_latency got %0d exp 2000", t_err - t_rel); end
        checks++;
        if (n_err - e0 !== 1) begin errors++; $display("FAIL timeout_error_pulses got %0d exp 1", n_err - e0); end
        checks++;
        if (n_listo - l0 !== 0) begin errors++; $display("FAIL timeout_listo got %0d exp 0", n_listo - l0); end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, ocupado} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_lines got %b exp 000", {ps2_clk_oe, ps2_data_oe, ocupado});
        end
    endtask

    task automatic test_busy_ignore();
        logic [9:0] smp;
        logic ok, ok2;
        int l0, c0;
        l0 = n_listo; c0 = n_clkoe;
        start_tx(8'hED);
        fork
            device_frame(1'b1, 0, smp, ok);
            begin
                repeat (200) @(negedge CLK_chaos);
                dato_tx = 8'h55;
                enviar  = 1'b1;
                @(negedge CLK_chaos);
                enviar  = 1'b0;
            end
        join
        wait_idle(ok2);
        repeat (50) @(negedge CLK_chaos);
        checks++;
        if (smp[7:0] !== 8'hED) begin errors++; $display("FAIL busy_data got %h exp ed", smp[7:0]); end
        checks++;
        if (n_listo - l0 !== 1) begin errors++; $display("FAIL busy_listo got %0d exp 1", n_listo - l0); end
        checks++;
        if (n_clkoe - c0 !== 9) begin errors++; $display("FAIL busy_no_second_frame got %0d exp 9", n_clkoe - c0); end
    endtask

    task automatic test_restart();
        logic [9:0] smp;
        logic ok;
        int l0, e0;
        l0 = n_listo; e0 = n_err;
        start_tx(8'hED);
        device_frame(1'b1, 5, smp, ok);
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, ocupado} !== 3'b000) begin
            errors++;
            $display("FAIL restart_lines got %b exp 000", {ps2_clk_oe, ps2_data_oe, ocupado});
        end
        repeat (100) @(negedge CLK_chaos);
        checks++;
        if ((n_listo - l0) + (n_err - e0) !== 0) begin
            errors++;
            $display("FAIL restart_pulses got %0d exp 0", (n_listo - l0) + (n_err - e0));
        end
        test_send(8'hFF, 1'b1);
    endtask

    task automatic test_invariants();
        checks++;
        if (n_viol !== 0) begin errors++; $display("FAIL invariants got %0d exp 0", n_viol); end
    endtask

    initial begin
        test_reset();
        test_send(8'hED, 1'b1);
        test_send(8'h07, 1'b0);
        test_send(8'h00, 1'b1);
        test_no_ack();
        test_timeout();
        test_busy_ignore();
        test_restart();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Serializes one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the alarm controller onto the keyboard's open-drain clock/data lines.
- Performs request-to-send, shifts the frame on device-generated clock edges and checks the device ACK.
- It is the outbound counterpart of the scan-code path that feeds `dato` into the keyboard-command decoder.

Parameters:
- INHIBIT_CYCLES, 5000, CLK_chaos cycles the clock line is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, max CLK_chaos cycles from clock release to ACK before aborting (15 ms at 50 MHz). The counter is 20 bits wide.

Ports:
- CLK_chaos  in  1  system clock.
- restart  in  1  synchronous, active-high reset.
- dato_tx  in  8  byte to transmit.
- enviar  in  1  send strobe; sampled only in IDLE.
- ps2_clk_in  in  1  raw PS/2 clock pin level.
- ps2_data_in  in  1  raw PS/2 data pin level.
- ps2_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release.
- ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release.
- ocupado  out  1  busy; high in every non-IDLE state.
- listo  out  1  one-cycle pulse: byte sent and ACKed.
- error  out  1  one-cycle pulse: timeout or missing ACK.

Behaviour:
- Reset (restart=1 at a CLK_chaos edge) sets the following, regardless of state and including mid-frame:
  - state = IDLE; all outputs 0, so both lines are released on the next cycle.
  - synchronizer flops = 1; edge counter and cycle counter = 0.
- Input synchronization:
  - ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer; a third flop on the clock gives clk_prev.
  - fall = clk_prev & ~clk_sync. A pin falling edge yields fall within 3 cycles.
  - fall is ignored in IDLE, INHIBIT and REQ.
- IDLE:
  - On enviar=1: latch dato_tx into shreg and latch par = ~^dato_tx (odd parity).
  - Clear counters and go to INHIBIT. ocupado=1 from the next cycle.
- INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
- REQ: clk_oe=1, data_oe=1 for exactly 1 cycle (start bit placed), then TX with cycle counter cleared.
- TX:
  - clk_oe=0. The cycle counter increments every cycle.
  - Each fall increments edge count n (1..11) and updates data_oe on the next cycle:
    - n=1..8: data_oe = ~shreg[n-1] (LSB first).
    - n=9: data_oe = ~par.
    - n=10: data_oe = 0 (stop bit, line released).
    - n=11: sample data_sync. If 0 (ACK), go to WAIT_REL. If 1, error pulse and go to IDLE.
- WAIT_REL:
  - All oe = 0. Wait until clk_sync=1 and data_sync=1.
  - Then listo pulses 1 cycle and the block returns to IDLE. ocupado=0 in that same cycle.
- Timeout: in TX or WAIT_REL, when the cycle counter reaches TIMEOUT_CYCLES:
  - release both lines, pulse error 1 cycle, go to IDLE.
  - Timeout takes priority over a simultaneous fall.
- listo and error never assert in the same cycle and never assert outside these transitions.
- enviar while ocupado=1 is ignored: no queueing, and the latched byte is unchanged.
- enviar in the same cycle listo/error pulses: ocupado is 0 in that cycle, so the strobe is accepted and a new frame starts.
- Line invariants: ps2_clk_oe is 1 only in INHIBIT/REQ; ps2_data_oe is 1 only in REQ/TX.

Test Plan (bench uses INHIBIT_CYCLES=8, TIMEOUT_CYCLES=2000, device model clocks at 40-cycle period):
- Send 0xED with the model ACKing:
  - clk_oe high 9 cycles, data_oe high during the last of them.
  - Model samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - listo pulses once, ocupado falls, error stays 0.
- Send 0x07: sampled parity = 0. Send 0x00: sampled parity = 1. Both ACKed, listo pulses each time.
- Model drives data high at edge 11 (no ACK): error pulses 1 cycle, listo=0, both oe=0 afterward.
- Model never clocks after request-to-send: error pulses exactly 2000 cycles after clk_oe drops; state returns to IDLE.
- enviar pulsed again mid-frame with 0x55: frame still carries 0xED and only one listo occurs.
- Assert restart at edge 5 of a frame: both oe are 0 and ocupado=0 the next cycle, with no listo/error pulse. A following 0xFF send completes normally.
